clk_div_scheduler: RTL and testbench

//  Synthesizable, runtime-programmable clock-enable scheduler for the memory/comms test fabric.

---
 rtl/clk_div_scheduler.sv | 131 +++++++++++++
 tb/tb_clk_div_scheduler.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/clk_div_scheduler.sv
// Runtime-programmable clock-enable scheduler: 50%-duty divided clock plus registered rise/fall strobes.
// Start/stop is glitch-free and divisor reloads take effect only on a phase boundary via a req/ack handshake.
module clk_div_scheduler #(
  parameter int ClkIn_kHz  = 50_000,
  parameter int DivWidth   = 16,
  parameter int DefaultDiv = 2
) (
  input  logic                _iClk,
  input  logic                _iRst_n,
  input  logic                _iEn,
  input  logic [DivWidth-1:0] _iDiv,
  input  logic                _iLoadReq,
  output logic                _oLoadAck,
  output logic                _oClk,
  output logic                _oRise,
  output logic                _oFall,
  output logic                _oRunning
);

  // A nonsensical configuration falls back to the fastest legal divisor.
  localparam logic [DivWidth-1:0] ResetDiv =
    (DefaultDiv >= 1 && ClkIn_kHz > 0) ? DivWidth'(DefaultDiv) : DivWidth'(1);

  typedef enum logic [1:0] {
    Idle,
    Run,
    Stopping
  } state_t;

  state_t              state, stateNext;
  logic [DivWidth-1:0] cnt, cntNext;
  logic [DivWidth-1:0] div, divNext;
  logic [DivWidth-1:0] normDiv;
  logic                clkQ, clkNext;
  logic                riseQ, riseNext;
  logic                fallQ, fallNext;
  logic                ackQ, ackNext;
  logic                armed, armedNext;
  logic                loadOk;
  logic                terminal;
  logic                toggled;

  // div is stored already normalised, so a requested 0 behaves as 1.
  assign normDiv  = (_iDiv == '0) ? DivWidth'(1) : _iDiv;
  assign loadOk   = _iLoadReq && armed;
  assign terminal = (cnt == (div - DivWidth'(1)));

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    divNext   = div;
    clkNext   = clkQ;
    riseNext  = 1'b0;
    fallNext  = 1'b0;
    ackNext   = 1'b0;
    armedNext = armed | ~_iLoadReq;
    toggled   = clkQ;
    unique case (state)
      Idle: begin
        cntNext = '0;
        clkNext = 1'b0;
        // A load coinciding with start-up lands before the first count.
        if (loadOk) begin
          divNext   = normDiv;
          ackNext   = 1'b1;
          armedNext = 1'b0;
        end
        if (_iEn) stateNext = Run;
      end
      Run, Stopping: begin
        if (terminal) begin
          toggled  = ~clkQ;
          cntNext  = '0;
          riseNext = ~clkQ;
          fallNext = clkQ;
          if (loadOk) begin
            divNext   = normDiv;
            ackNext   = 1'b1;
            armedNext = 1'b0;
          end
        end else begin
          cntNext = cnt + DivWidth'(1);
        end
        clkNext = toggled;
        // The stop decision looks at the clock value after any toggle this edge.
        if (_iEn) begin
          stateNext = Run;
        end else if (toggled) begin
          stateNext = Stopping;
        end else begin
          stateNext = Idle;
          cntNext   = '0;
        end
      end
      default: begin
        stateNext = Idle;
        cntNext   = '0;
        clkNext   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge _iClk or negedge _iRst_n) begin
    if (!_iRst_n) begin
      state <= Idle;
      cnt   <= '0;
      div   <= ResetDiv;
      clkQ  <= 1'b0;
      riseQ <= 1'b0;
      fallQ <= 1'b0;
      ackQ  <= 1'b0;
      armed <= 1'b1;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      div   <= divNext;
      clkQ  <= clkNext;
      riseQ <= riseNext;
      fallQ <= fallNext;
      ackQ  <= ackNext;
      armed <= armedNext;
    end
  end

  assign _oClk      = clkQ;
  assign _oRise     = riseQ;
  assign _oFall     = fallQ;
  assign _oLoadAck  = ackQ;
  assign _oRunning  = (state != Idle);

endmodule

// File: tb/tb_clk_div_scheduler.sv
// Directed bench for clk_div_scheduler; each step compares {clk,rise,fall,running,ack} after one edge.
module tb_clk_div_scheduler;

  logic        clk;
  logic        rstN;
  logic        en;
  logic [15:0] divIn;
  logic        loadReq;
  logic        loadAck;
  logic        dClk;
  logic        rise;
  logic        fall;
  logic        running;

  int nCompared;
  int nMismatched;
  logic [4:0] expSeq[$];
  logic [4:0] obsVec;

  assign obsVec = {dClk, rise, fall, running, loadAck};

  clk_div_scheduler #(
    .ClkIn_kHz (50_000),
    .DivWidth  (16),
    .DefaultDiv(2)
  ) dut (
    ._iClk    (clk),
    ._iRst_n  (rstN),
    ._iEn     (en),
    ._iDiv    (divIn),
    ._iLoadReq(loadReq),
    ._oLoadAck(loadAck),
    ._oClk    (dClk),
    ._oRise   (rise),
    ._oFall   (fall),
    ._oRunning(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: observed clk/rise/fall/run/ack=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic stepCheck(input string tag, input logic [4:0] exp);
    @(negedge clk);
    checkVal(tag, obsVec, exp);
  endtask

  task automatic playSeq(input string tag);
    foreach (expSeq[i]) stepCheck($sformatf("%s[%0d]", tag, i), expSeq[i]);
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rstN    = 1'b0;
    en      = 1'b1;
    divIn   = 16'd0;
    loadReq = 1'b0;

    // 1: reset state, then default div=2 start-up
    for (int i = 0; i < 5; i++) stepCheck($sformatf("rst[%0d]", i), 5'b00000);
    rstN = 1'b1;
    expSeq = '{5'b00010, 5'b00010, 5'b11010, 5'b10010, 5'b00110,
               5'b00010, 5'b11010, 5'b10010, 5'b00110};
    playSeq("div2");
    en = 1'b0;
    stepCheck("div2Stop", 5'b00000);

    // 2: idle load of div=3, then run
    divIn = 16'd3; loadReq = 1'b1;
    stepCheck("idleLoadAck", 5'b00001);
    loadReq = 1'b0; en = 1'b1;
    expSeq = '{5'b00010, 5'b00010, 5'b00010, 5'b11010, 5'b10010, 5'b10010,
               5'b00110, 5'b00010, 5'b00010, 5'b11010, 5'b10010, 5'b10010,
               5'b00110, 5'b00010, 5'b00010, 5'b11010};
    playSeq("div3");

    // 3: running reload to div=1, acked at the next fall
    divIn = 16'd1; loadReq = 1'b1;
    expSeq = '{5'b10010, 5'b10010, 5'b00111};
    playSeq("runLoad1");
    loadReq = 1'b0;
    expSeq = '{5'b11010, 5'b00110, 5'b11010, 5'b00110};
    playSeq("div1");

    // 4: reload to div=4, then stop during a high phase
    divIn = 16'd4; loadReq = 1'b1;
    stepCheck("runLoad4", 5'b11011);
    loadReq = 1'b0;
    expSeq = '{5'b10010, 5'b10010, 5'b10010, 5'b00110,
               5'b00010, 5'b00010, 5'b00010, 5'b11010};
    playSeq("div4");
    en = 1'b0;
    expSeq = '{5'b10010, 5'b10010, 5'b10010, 5'b00100, 5'b00000};
    playSeq("stopping");

    // 4b: restart, stop, and re-raise enable inside STOPPING
    en = 1'b1;
    expSeq = '{5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b11010};
    playSeq("restart4");
    en = 1'b0;
    stepCheck("reStop", 5'b10010);
    en = 1'b1;
    expSeq = '{5'b10010, 5'b10010, 5'b00110, 5'b00010,
               5'b00010, 5'b00010, 5'b11010};
    playSeq("resume");
    en = 1'b0;
    expSeq = '{5'b10010, 5'b10010, 5'b10010, 5'b00100};
    playSeq("stop2");

    // 5: div=0 behaves as 1; load at the same edge as start-up
    divIn = 16'd0; loadReq = 1'b1; en = 1'b1;
    stepCheck("startLoad0", 5'b00011);
    loadReq = 1'b0;
    expSeq = '{5'b11010, 5'b00110, 5'b11010, 5'b00110};
    playSeq("div0");
    // enable drops on a terminal that raises the clock -> one more high cycle
    en = 1'b0;
    expSeq = '{5'b11010, 5'b00100};
    playSeq("stopOnTerm");

    // 6: async reset mid high phase with a load pending
    divIn = 16'd6; loadReq = 1'b1;
    stepCheck("idleLoad6", 5'b00001);
    loadReq = 1'b0; en = 1'b1;
    expSeq = '{5'b00010, 5'b00010, 5'b00010, 5'b00010,
               5'b00010, 5'b00010, 5'b11010};
    playSeq("div6");
    divIn = 16'd2; loadReq = 1'b1;
    expSeq = '{5'b10010, 5'b10010};
    playSeq("pending");
    rstN = 1'b0;
    #1;
    checkVal("asyncRst", obsVec, 5'b00000);
    stepCheck("inRst0", 5'b00000);
    stepCheck("inRst1", 5'b00000);
    loadReq = 1'b0; rstN = 1'b1; en = 1'b1;
    expSeq = '{5'b00010, 5'b00010, 5'b11010, 5'b10010, 5'b00110};
    playSeq("postRst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
